// File: rtl/sd_route_ctrl.sv
// sd_route_ctrl: arbitrates the core's single SPI SD master between the HPS
// virtual SD image (sd_card) and the physical SD slot.
//
// The route (vsd_sel) only changes while the SPI bus is idle, so no transaction
// is split across devices. If the bus never goes idle, a pending switch is
// forced after FORCE_WAIT cycles. A mount can optionally raise mount_reset for
// RST_PULSE cycles. Activity LEDs stay lit for ACT_HOLD cycles after the last
// MOSI/MISO toggle.
//
// Ports:
//   clk_sys, reset          system clock, synchronous active-high reset
//   img_mounted             mount strobe (level); its rising edge is used
//   img_size_nz             1 = image present, so route to the virtual SD
//   reset_on_mount          enable mount_reset generation
//   spi_ss/sck/mosi/miso    core-side SPI (ss is active-low)
//   vsd_miso, vsd_ss        sd_card side
//   phy_miso/cs/sck/mosi    SD_* pin side
//   vsd_sel                 current route, 1 = virtual
//   mount_reset             reset request pulse
//   led_vsd, led_phy        per-device activity
module sd_route_ctrl #(
  parameter int ACT_HOLD    = 1000000,
  parameter int SWITCH_IDLE = 64,
  parameter int FORCE_WAIT  = 4194304,
  parameter int RST_PULSE   = 16
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic img_mounted,
  input  logic img_size_nz,
  input  logic reset_on_mount,
  input  logic spi_ss,
  input  logic spi_sck,
  input  logic spi_mosi,
  output logic spi_miso,
  input  logic vsd_miso,
  input  logic phy_miso,
  output logic vsd_ss,
  output logic phy_cs,
  output logic phy_sck,
  output logic phy_mosi,
  output logic vsd_sel,
  output logic mount_reset,
  output logic led_vsd,
  output logic led_phy
);

  localparam int IW = $clog2(SWITCH_IDLE + 1);
  localparam int FW = $clog2(FORCE_WAIT + 1);
  localparam int RW = $clog2(RST_PULSE + 1);
  localparam int AW = $clog2(ACT_HOLD + 1);

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_SWITCH = 2'd2;
  localparam logic [1:0] S_PULSE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          sel_q, sel_d;
  logic          pend_q, pend_d;
  logic          psel_q, psel_d;
  logic          mnt_q;
  logic          mrst_q, mrst_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [FW-1:0] force_q, force_d;
  logic [RW-1:0] rst_q, rst_d;
  logic [AW-1:0] act_q, act_d;
  logic          mosi_q, miso_q;
  logic          mnt_rise;
  logic          go;
  logic          toggle;
  logic          act;

  // Routing is driven only from the registered select, so it never glitches
  // mid-transaction.
  assign vsd_sel     = sel_q;
  assign mount_reset = mrst_q;
  assign vsd_ss      = spi_ss | ~sel_q;
  assign phy_cs      = spi_ss | sel_q;
  assign phy_sck     = spi_sck & ~sel_q;
  assign phy_mosi    = spi_mosi & ~sel_q;
  assign spi_miso    = sel_q ? vsd_miso : phy_miso;

  assign mnt_rise = img_mounted & ~mnt_q;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    pend_d  = pend_q;
    psel_d  = psel_q;
    idle_d  = idle_q;
    force_d = force_q;
    rst_d   = rst_q;
    mrst_d  = mrst_q;
    go      = 1'b0;
    case (state_q)
      S_RUN: begin
        if (pend_q) begin
          state_d = S_WAIT;
          idle_d  = '0;
          force_d = '0;
        end
      end
      S_WAIT: begin
        idle_d  = spi_ss ? idle_q + 1'b1 : '0;
        force_d = force_q + 1'b1;
        // idle_q counts earlier high cycles; the current high cycle completes
        // the SWITCH_IDLE run.
        go = (spi_ss && (idle_q == IW'(SWITCH_IDLE - 1))) ||
             (force_q == FW'(FORCE_WAIT - 1));
        if (go) begin
          sel_d   = psel_q;
          pend_d  = 1'b0;
          state_d = S_SWITCH;
        end
      end
      S_SWITCH: begin
        if (reset_on_mount) begin
          rst_d   = RW'(RST_PULSE - 1);
          mrst_d  = 1'b1;
          state_d = S_PULSE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_PULSE: begin
        if (rst_q == '0) begin
          mrst_d  = 1'b0;
          state_d = S_RUN;
        end else begin
          rst_d = rst_q - 1'b1;
        end
      end
      default: state_d = S_RUN;
    endcase
    // A mount seen in the same cycle as a switch stays pending for the next pass.
    if (mnt_rise) begin
      pend_d = 1'b1;
      psel_d = img_size_nz;
    end
  end

  // Activity stretch: any MOSI/MISO toggle restarts the hold window.
  assign toggle = (spi_mosi ^ mosi_q) | (spi_miso ^ miso_q);
  assign act    = act_q < AW'(ACT_HOLD);
  assign led_vsd = act & sel_q;
  assign led_phy = act & ~sel_q;

  always_comb begin
    act_d = act_q;
    if (toggle)                        act_d = '0;
    else if (act_q != AW'(ACT_HOLD))   act_d = act_q + 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= S_RUN;
      sel_q   <= 1'b0;
      pend_q  <= 1'b0;
      psel_q  <= 1'b0;
      mnt_q   <= 1'b0;
      mrst_q  <= 1'b0;
      idle_q  <= '0;
      force_q <= '0;
      rst_q   <= '0;
      act_q   <= AW'(ACT_HOLD);
      mosi_q  <= 1'b0;
      miso_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      pend_q  <= pend_d;
      psel_q  <= psel_d;
      mnt_q   <= img_mounted;
      mrst_q  <= mrst_d;
      idle_q  <= idle_d;
      force_q <= force_d;
      rst_q   <= rst_d;
      act_q   <= act_d;
      mosi_q  <= spi_mosi;
      miso_q  <= spi_miso;
    end
  end

endmodule

// File: tb/tb_sd_route_ctrl.sv
// Bench for sd_route_ctrl: random SPI traffic checked every cycle against a
// behavioural model, plus directed timing checks for each scenario.
module tb_sd_route_ctrl;
  localparam int ACT_HOLD    = 100;
  localparam int SWITCH_IDLE = 8;
  localparam int FORCE_WAIT  = 50;
  localparam int RST_PULSE   = 4;

  logic clk_sys = 1'b0;
  logic reset = 1'b1, img_mounted = 1'b0, img_size_nz = 1'b0, reset_on_mount = 1'b0;
  logic spi_ss = 1'b1, spi_sck = 1'b0, spi_mosi = 1'b0, vsd_miso = 1'b0, phy_miso = 1'b0;
  logic spi_miso, vsd_ss, phy_cs, phy_sck, phy_mosi, vsd_sel, mount_reset, led_vsd, led_phy;

  always #5 clk_sys = ~clk_sys;

  sd_route_ctrl #(
    .ACT_HOLD(ACT_HOLD), .SWITCH_IDLE(SWITCH_IDLE),
    .FORCE_WAIT(FORCE_WAIT), .RST_PULSE(RST_PULSE)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .img_mounted(img_mounted),
    .img_size_nz(img_size_nz), .reset_on_mount(reset_on_mount),
    .spi_ss(spi_ss), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .vsd_miso(vsd_miso), .phy_miso(phy_miso), .vsd_ss(vsd_ss), .phy_cs(phy_cs),
    .phy_sck(phy_sck), .phy_mosi(phy_mosi), .vsd_sel(vsd_sel),
    .mount_reset(mount_reset), .led_vsd(led_vsd), .led_phy(led_phy)
  );

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Model phases: idle, waiting for a quiet bus, settle cycle, reset pulse.
  localparam int P_IDLE = 0, P_ARM = 1, P_SET = 2, P_PLS = 3;
  int cyc = 0;
  bit m_valid = 0;
  bit m_sel = 0, m_pend = 0, m_psel = 0, m_pm = 0, m_pmosi = 0, m_pmiso = 0;
  int m_ph = P_IDLE, m_hi = 0, m_age = 0, m_pls = 0, m_last = -1000000;

  // Stimulus wishes, applied at the next negedge.
  bit w_rst = 1, w_mnt = 0, w_nz = 0, w_rom = 0, w_ss = 1, w_mosi = 0, noise = 1;

  // Observed DUT events.
  logic d_sel_prev = 1'b0;
  int d_sw_cyc = -1, d_nsw = 0, d_mr_cnt = 0, d_mr_first = -1;

  task automatic clr_obs();
    d_sw_cyc = -1; d_nsw = 0; d_mr_cnt = 0; d_mr_first = -1;
  endtask

  task automatic cmp_cycle();
    logic exp_miso;
    bit act;
    if (!m_valid) return;
    exp_miso = m_sel ? vsd_miso : phy_miso;
    act = (cyc - m_last) <= ACT_HOLD;
    chk("vsd_ss", vsd_ss, spi_ss | !m_sel);
    chk("phy_cs", phy_cs, spi_ss | m_sel);
    chk("phy_sck", phy_sck, spi_sck & !m_sel);
    chk("phy_mosi", phy_mosi, spi_mosi & !m_sel);
    chk("spi_miso", spi_miso, exp_miso);
    chk("vsd_sel", vsd_sel, m_sel);
    chk("mount_reset", mount_reset, m_pls > 0);
    chk("led_vsd", led_vsd, act && m_sel);
    chk("led_phy", led_phy, act && !m_sel);
    if (vsd_sel !== d_sel_prev) begin d_nsw++; d_sw_cyc = cyc; end
    d_sel_prev = vsd_sel;
    if (mount_reset === 1'b1) begin
      if (d_mr_cnt == 0) d_mr_first = cyc;
      d_mr_cnt++;
    end
  endtask

  task automatic advance();
    bit nsel, npend, npsel, rise;
    logic exp_miso;
    exp_miso = m_sel ? vsd_miso : phy_miso;
    if (reset) begin
      m_valid = 1; m_sel = 0; m_pend = 0; m_psel = 0; m_pm = 0;
      m_ph = P_IDLE; m_hi = 0; m_age = 0; m_pls = 0;
      m_pmosi = 0; m_pmiso = 0; m_last = -1000000;
    end else begin
      if ((spi_mosi != m_pmosi) || (exp_miso != m_pmiso)) m_last = cyc;
      m_pmosi = spi_mosi; m_pmiso = exp_miso;
      rise = img_mounted && !m_pm;
      m_pm = img_mounted;
      nsel = m_sel; npend = m_pend; npsel = m_psel;
      case (m_ph)
        P_IDLE: if (m_pend) begin m_ph = P_ARM; m_hi = 0; m_age = 0; end
        P_ARM: begin
          if ((spi_ss && m_hi + 1 == SWITCH_IDLE) || m_age + 1 == FORCE_WAIT) begin
            nsel = m_psel; npend = 0; m_ph = P_SET;
          end
          m_hi = spi_ss ? m_hi + 1 : 0;
          m_age++;
        end
        P_SET: if (reset_on_mount) begin m_pls = RST_PULSE; m_ph = P_PLS; end
               else m_ph = P_IDLE;
        default: begin m_pls--; if (m_pls == 0) m_ph = P_IDLE; end
      endcase
      if (rise) begin npend = 1; npsel = img_size_nz; end
      m_sel = nsel; m_pend = npend; m_psel = npsel;
    end
    cyc++;
  endtask

  task automatic step();
    @(negedge clk_sys);
    reset = w_rst; img_mounted = w_mnt; img_size_nz = w_nz;
    reset_on_mount = w_rom; spi_ss = w_ss;
    spi_sck = 1'($urandom);
    if (noise) begin
      spi_mosi = 1'($urandom); vsd_miso = 1'($urandom); phy_miso = 1'($urandom);
    end else begin
      spi_mosi = w_mosi; vsd_miso = 1'b0; phy_miso = 1'b0;
    end
    #1;
    cmp_cycle();
    advance();
  endtask

  initial begin
    int e, n, np, h;
    repeat (3) step();
    w_rst = 0;
    step();
    chk("rst_sel", vsd_sel, 0);
    chk("rst_mr", mount_reset, 0);
    chk("rst_leds", {led_vsd, led_phy}, 0);

    // 1: idle bus, mount to virtual
    clr_obs(); w_ss = 1; w_rom = 0; e = cyc;
    for (int k = 0; k < 25; k++) begin w_mnt = (k < 2); w_nz = 1; step(); end
    chk("t1_lat", d_sw_cyc - e, 10);
    chk("t1_nsw", d_nsw, 1);
    chk("t1_mr", d_mr_cnt, 0);
    w_ss = 0; step();
    chk("t1_phycs", phy_cs, 1);
    chk("t1_vss_lo", vsd_ss, 0);
    w_ss = 1; step();
    chk("t1_vss_hi", vsd_ss, 1);

    // 2: busy bus, forced switch back to physical
    clr_obs(); e = cyc;
    for (int k = 0; k < 70; k++) begin
      w_ss = (k % 5 != 4); w_mnt = (k < 2); w_nz = 0; step();
    end
    chk("t2_lat", d_sw_cyc - e, FORCE_WAIT + 2);
    chk("t2_sel", vsd_sel, 0);

    // 3: bus goes idle after 20 busy cycles
    clr_obs(); e = cyc;
    for (int k = 0; k < 50; k++) begin
      w_ss = (k >= 20); w_mnt = (k < 2); w_nz = 1; step();
    end
    chk("t3_lat", d_sw_cyc - e, 20 + SWITCH_IDLE);
    chk("t3_sel", vsd_sel, 1);

    // 5: second mount overrides the first while waiting
    clr_obs(); e = cyc; w_ss = 1;
    for (int k = 0; k < 30; k++) begin
      w_mnt = (k < 2) || (k == 3) || (k == 4); w_nz = (k < 3); step();
    end
    chk("t5_nsw", d_nsw, 1);
    chk("t5_lat", d_sw_cyc - e, 10);
    chk("t5_sel", vsd_sel, 0);

    // 4: mount with reset pulse, route unchanged at physical
    clr_obs(); e = cyc; w_rom = 1;
    for (int k = 0; k < 30; k++) begin w_mnt = (k < 2); w_nz = 0; step(); end
    chk("t4_sel", vsd_sel, 0);
    chk("t4_nsw", d_nsw, 0);
    chk("t4_mr_len", d_mr_cnt, RST_PULSE);
    chk("t4_mr_at", d_mr_first - e, 11);

    // 6: LEDs on virtual route, then reset mid-pulse
    w_rom = 0;
    for (int k = 0; k < 20; k++) begin w_mnt = (k < 2); w_nz = 1; step(); end
    chk("t6_sel", vsd_sel, 1);
    noise = 0; w_mosi = 0;
    repeat (120) step();
    chk("t6_quiet", {led_vsd, led_phy}, 0);
    w_mosi = 1; n = 0; np = 0;
    for (int k = 0; k < 130; k++) begin
      step();
      if (led_vsd === 1'b1) n++;
      if (led_phy !== 1'b0) np++;
    end
    chk("t6_led_len", n, ACT_HOLD);
    chk("t6_led_phy", np, 0);
    w_rom = 1; h = 0;
    for (int k = 0; k < 40; k++) begin
      w_mnt = (k < 2); w_nz = 1; step();
      if (mount_reset === 1'b1) h++;
      if (h == 2) break;
    end
    chk("t6_pulse_seen", h, 2);
    w_mnt = 0; w_rst = 1; step();
    w_rst = 0; step();
    chk("t6_rst_mr", mount_reset, 0);
    chk("t6_rst_sel", vsd_sel, 0);
    noise = 1; w_rom = 0;
    repeat (10) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
